muldiv_seq_ctrl: RTL

- Sequencer between the execute stage and the shared multi-cycle M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Issues exactly one start pulse per instruction and registers operands for the unit.
- Generates the pipeline stall, holds the result until the pipeline advances, and resolves RISC-V divide special cases in zero cycles.
- Drains the unit on flush and enforces a timeout so a hung unit cannot lock the core.

---
 rtl/muldiv_seq_ctrl_pkg.sv | 25 ++
 rtl/muldiv_fastpath.sv | 39 +++
 rtl/muldiv_seq_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_ctrl_pkg.sv
// Shared definitions for the M-extension sequencer: funct3 operation codes,
// sequencer state encoding and the RISC-V divide special-case constants.
package muldiv_seq_ctrl_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [31:0] MIN_INT32  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES32 = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_fastpath.sv
// Zero-cycle resolution of RISC-V divide special cases.
// Ports:
//   funct3 - M-extension operation select
//   rs1    - dividend
//   rs2    - divisor
//   hit    - operation is a special case and needs no multi-cycle unit
//   value  - architectural result when hit is set (0 otherwise)
module muldiv_fastpath
  import muldiv_seq_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] rs1,
  input  logic [DATA_WIDTH-1:0] rs2,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] value
);

  localparam logic [DATA_WIDTH-1:0] MIN_INT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic by_zero;
  logic overflow;

  always_comb begin
    // funct3[2] selects the divide group, funct3[1] selects remainder.
    by_zero  = funct3[2] && (rs2 == '0);
    overflow = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (rs1 == MIN_INT) && (rs2 == '1);
    hit      = by_zero || overflow;
    value    = '0;
    if (by_zero) begin
      value = funct3[1] ? rs1 : '1;
    end else if (overflow) begin
      value = funct3[1] ? '0 : MIN_INT;
    end
  end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Sequencer between the execute stage and the shared multi-cycle M unit.
// Issues one start pulse per instruction, registers operands, stalls the
// pipeline while the unit works, holds the result until the pipeline
// advances, resolves divide special cases in zero cycles, drains the unit
// on flush and forces completion after TIMEOUT_CYCLES.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   req_valid_i       - execute stage holds an M-extension op
//   funct3_i, rs1_i, rs2_i - operation and operands
//   flush_i           - kill the current instruction
//   pipe_stall_i      - pipeline held by another source
//   unit_start_o      - one-cycle start pulse to the unit
//   unit_rs1_o, unit_rs2_o, unit_funct3_o - registered unit operands
//   unit_result_i, unit_busy_i - unit result / busy flag
//   result_o, result_valid_o  - result to the writeback mux
//   stall_o           - pipeline stall request
//   timeout_o         - one-cycle pulse when the timeout fires
module muldiv_seq_ctrl
  import muldiv_seq_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_WIDTH      = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  input  logic                  flush_i,
  input  logic                  pipe_stall_i,
  output logic                  unit_start_o,
  output logic [DATA_WIDTH-1:0] unit_rs1_o,
  output logic [DATA_WIDTH-1:0] unit_rs2_o,
  output logic [2:0]            unit_funct3_o,
  input  logic [DATA_WIDTH-1:0] unit_result_i,
  input  logic                  unit_busy_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  result_valid_o,
  output logic                  stall_o,
  output logic                  timeout_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] rs1_q, rs2_q, res_q;
  logic [2:0]            f3_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic                  fp_hit;
  logic [DATA_WIDTH-1:0] fp_value;

  logic accept, capture, expire, cnt_clear, cnt_inc;

  muldiv_fastpath #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fastpath (
    .funct3(funct3_i),
    .rs1   (rs1_i),
    .rs2   (rs2_i),
    .hit   (fp_hit),
    .value (fp_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      rs1_q <= '0;
      rs2_q <= '0;
      f3_q  <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        rs1_q <= rs1_i;
        rs2_q <= rs2_i;
        f3_q  <= funct3_i;
      end
      if (capture) begin
        res_q <= unit_result_i;
      end else if (expire) begin
        res_q <= '0;
      end
      if (cnt_clear) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state;
    unit_start_o   = 1'b0;
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    result_o       = '0;
    timeout_o      = 1'b0;
    accept         = 1'b0;
    capture        = 1'b0;
    expire         = 1'b0;
    cnt_clear      = 1'b0;
    cnt_inc        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_valid_i && !flush_i) begin
          if (fp_hit) begin
            result_valid_o = 1'b1;
            result_o       = fp_value;
          end else begin
            accept     = 1'b1;
            stall_o    = 1'b1;
            state_next = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (flush_i) begin
          state_next = ST_IDLE;
        end else begin
          unit_start_o = 1'b1;
          stall_o      = 1'b1;
          cnt_clear    = 1'b1;
          state_next   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush_i) begin
          state_next = unit_busy_i ? ST_DRAIN : ST_IDLE;
        end else begin
          stall_o = 1'b1;
          cnt_inc = 1'b1;
          if (!unit_busy_i) begin
            capture    = 1'b1;
            state_next = ST_HOLD;
          end else if (cnt_q == CNT_LAST) begin
            // This is the TIMEOUT_CYCLES-th WAIT cycle with busy still high.
            expire     = 1'b1;
            timeout_o  = 1'b1;
            state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (flush_i) begin
          state_next = ST_IDLE;
        end else begin
          result_valid_o = 1'b1;
          result_o       = res_q;
          if (!pipe_stall_i) begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        // The killed result is discarded; a waiting new op keeps the stall.
        stall_o = req_valid_i;
        if (!unit_busy_i) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign unit_rs1_o    = rs1_q;
  assign unit_rs2_o    = rs2_q;
  assign unit_funct3_o = f3_q;

endmodule
